countdown_timer: RTL and testbench

- Countdown timer stage that consumes the mode-decoder outputs modo_timer and modo_ajuste_timer.
- Holds a preset in MM:SS BCD, edited in timer-adjust mode, and counts it down on a 1 Hz tick.
- Asserts an alarm at 00:00 and presents four BCD digits to the display mux.
- Keeps counting in the background when another mode is selected.

---
 rtl/countdown_timer.sv | 172 +++++++++++++++++
 tb/tb_countdown_timer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with adjustable preset, pause, and timed alarm.
// Optional display blink during PAUSE/EXPIRED is enabled by defining TIMER_BLINK_EN.
module countdown_timer #(
    parameter int ALARM_SECS = 10,
    parameter int MAX_MIN    = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       modo_timer,
    input  logic       modo_ajuste_timer,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_inc_min,
    input  logic       btn_inc_sec,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       running,
    output logic       alarm,
    output logic       blank
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    localparam logic [3:0] MAX_T      = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_U      = 4'(MAX_MIN % 10);
    localparam logic [3:0] ALARM_INIT = 4'(ALARM_SECS);

    // Time values are packed {min_tens, min_units, sec_tens, sec_units}.
    state_t      state_q, state_d;
    logic [15:0] preset_q, preset_d;
    logic [15:0] count_q, count_d;
    logic [3:0]  acnt_q, acnt_d;
    logic [15:0] count_dec;
    logic [7:0]  sec_inc, min_inc;
    logic        btn_ok;

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = v;
        if (su != 4'd0) su = su - 4'd1;
        else begin
            su = 4'd9;
            if (st != 4'd0) st = st - 4'd1;
            else begin
                st = 4'd5;
                if (mu != 4'd0) mu = mu - 4'd1;
                else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    always_comb begin
        count_dec = bcd_dec(count_q);

        // Seconds wrap 59 -> 00 on their own; no carry into minutes.
        if (preset_q[3:0] == 4'd9)
            sec_inc = (preset_q[7:4] == 4'd5) ? 8'h00 : {preset_q[7:4] + 4'd1, 4'd0};
        else
            sec_inc = {preset_q[7:4], preset_q[3:0] + 4'd1};

        if (preset_q[15:12] == MAX_T && preset_q[11:8] == MAX_U)
            min_inc = 8'h00;
        else if (preset_q[11:8] == 4'd9)
            min_inc = {preset_q[15:12] + 4'd1, 4'd0};
        else
            min_inc = {preset_q[15:12], preset_q[11:8] + 4'd1};
    end

    assign btn_ok = modo_timer && !modo_ajuste_timer;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d  = state_q;
        preset_d = preset_q;
        count_d  = count_q;
        acnt_d   = acnt_q;

        if (modo_ajuste_timer) begin
            state_d = IDLE;
            acnt_d  = 4'd0;
            if (btn_inc_sec) preset_d[7:0]  = sec_inc;
            if (btn_inc_min) preset_d[15:8] = min_inc;
        end else if (btn_ok && btn_clear) begin
            state_d = IDLE;
            count_d = preset_q;
            acnt_d  = 4'd0;
        end else if (btn_ok && btn_start) begin
            // A start press consumes any coincident tick.
            unique case (state_q)
                IDLE: if (preset_q != 16'h0000) begin
                    count_d = preset_q;
                    state_d = RUN;
                end
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                EXPIRED: begin
                    state_d = IDLE;
                    acnt_d  = 4'd0;
                end
                default: state_d = IDLE;
            endcase
        end else if (tick_1hz) begin
            unique case (state_q)
                RUN: if (count_q != 16'h0000) begin
                    count_d = count_dec;
                    if (count_dec == 16'h0000) begin
                        state_d = EXPIRED;
                        acnt_d  = ALARM_INIT;
                    end
                end
                EXPIRED: begin
                    if (acnt_q <= 4'd1) begin
                        state_d = IDLE;
                        count_d = preset_q;
                        acnt_d  = 4'd0;
                    end else begin
                        acnt_d = acnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            preset_q <= 16'h0000;
            count_q  <= 16'h0000;
            acnt_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            acnt_q   <= acnt_d;
        end
    end

`ifdef TIMER_BLINK_EN
    logic blink_q, blink_d;

    always_comb begin
        blink_d = blink_q;
        if (state_d == IDLE || state_d == RUN)
            blink_d = 1'b0;
        else if (tick_1hz && (state_q == PAUSE || state_q == EXPIRED))
            blink_d = !blink_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) blink_q <= 1'b0;
        else       blink_q <= blink_d;
    end

    assign blank = blink_q;
`else
    assign blank = 1'b0;
`endif

    assign {min_tens, min_units, sec_tens, sec_units} = (state_q == IDLE) ? preset_q : count_q;
    assign running = (state_q == RUN);
    assign alarm   = (state_q == EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for countdown_timer: expected display/status words are
// queued as stimulus is applied and popped when the outputs are sampled.
module tb_countdown_timer;

`ifdef TIMER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0, modo_timer = 1'b0, modo_ajuste_timer = 1'b0;
    logic       btn_start = 1'b0, btn_clear = 1'b0, btn_inc_min = 1'b0, btn_inc_sec = 1'b0;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic       running, alarm, blank;

    logic [18:0] exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;

    countdown_timer #(.ALARM_SECS(10), .MAX_MIN(99)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .modo_timer(modo_timer), .modo_ajuste_timer(modo_ajuste_timer),
        .btn_start(btn_start), .btn_clear(btn_clear),
        .btn_inc_min(btn_inc_min), .btn_inc_sec(btn_inc_sec),
        .min_tens(min_tens), .min_units(min_units),
        .sec_tens(sec_tens), .sec_units(sec_units),
        .running(running), .alarm(alarm), .blank(blank)
    );

    always #5 clk = ~clk;

    // Expected word: BCD MM:SS, running, alarm, blank (blank forced 0 without blink).
    function automatic logic [18:0] ex(input int m, input int s, input bit run,
                                       input bit alm, input bit blk);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), run, alm, BLINK & blk};
    endfunction

    task automatic check(input string tag);
        logic [18:0] obs, expv;
        obs = {min_tens, min_units, sec_tens, sec_units, running, alarm, blank};
        n_chk++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, observed=%h", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                n_err++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
            end
        end
    endtask

    task automatic pulse(input logic st, input logic cl, input logic im,
                         input logic is, input logic tk);
        btn_start = st; btn_clear = cl; btn_inc_min = im; btn_inc_sec = is; tick_1hz = tk;
        @(posedge clk); #1;
        btn_start = 0; btn_clear = 0; btn_inc_min = 0; btn_inc_sec = 0; tick_1hz = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        modo_timer = 0; modo_ajuste_timer = 0;
        reset = 1; #2; reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic set_preset(input int m, input int s);
        modo_ajuste_timer = 1;
        for (int i = 0; i < m; i++) pulse(0, 0, 1, 0, 0);
        for (int i = 0; i < s; i++) pulse(0, 0, 0, 1, 0);
        modo_ajuste_timer = 0;
        modo_timer = 1;
    endtask

    initial begin
        // Reset state
        #3;
        exp_q.push_back(ex(0, 0, 0, 0, 0));
        check("reset_outputs");
        #20 reset = 0;
        @(posedge clk); #1;

        // Preset editing: 3 min pulses, 75 sec pulses -> 03:15, sec wrap carries nothing
        modo_ajuste_timer = 1;
        for (int i = 0; i < 3; i++) pulse(0, 0, 1, 0, 0);
        for (int i = 0; i < 60; i++) pulse(0, 0, 0, 1, 0);
        exp_q.push_back(ex(3, 0, 0, 0, 0));
        check("sec_wrap_no_carry");
        for (int i = 0; i < 15; i++) pulse(0, 0, 0, 1, 0);
        exp_q.push_back(ex(3, 15, 0, 0, 0));
        check("preset_03_15");
        exp_q.push_back(ex(4, 16, 0, 0, 0));
        pulse(0, 0, 1, 1, 0);
        check("both_inc_same_cycle");

        // 00:03 countdown, expiry, 10-tick alarm, return to IDLE
        do_reset();
        set_preset(0, 3);
        exp_q.push_back(ex(0, 3, 1, 0, 0));
        pulse(1, 0, 0, 0, 1);
        check("start_no_decrement");
        exp_q.push_back(ex(0, 2, 1, 0, 0)); ticks(1); check("count_00_02");
        exp_q.push_back(ex(0, 1, 1, 0, 0)); ticks(1); check("count_00_01");
        exp_q.push_back(ex(0, 0, 0, 1, 0)); ticks(1); check("expired_alarm");
        exp_q.push_back(ex(0, 0, 0, 1, 1)); ticks(9); check("alarm_after_9");
        exp_q.push_back(ex(0, 3, 0, 0, 0)); ticks(1); check("alarm_done_idle");

        // 01:00 -> 00:59 borrow, pause with simultaneous tick, frozen
        do_reset();
        set_preset(1, 0);
        exp_q.push_back(ex(1, 0, 1, 0, 0)); pulse(1, 0, 0, 0, 0); check("run_01_00");
        exp_q.push_back(ex(0, 59, 1, 0, 0)); ticks(1); check("borrow_00_59");
        exp_q.push_back(ex(0, 59, 0, 0, 0)); pulse(1, 0, 0, 0, 1); check("pause_tick_dropped");
        exp_q.push_back(ex(0, 59, 0, 0, 1)); ticks(1); check("pause_blink_1");
        exp_q.push_back(ex(0, 59, 0, 0, 0)); ticks(1); check("pause_blink_2");
        exp_q.push_back(ex(0, 59, 0, 0, 1)); ticks(3); check("pause_frozen");

        // Background counting in clock mode, buttons ignored
        do_reset();
        set_preset(2, 10);
        exp_q.push_back(ex(2, 10, 1, 0, 0)); pulse(1, 0, 0, 0, 0); check("run_02_10");
        modo_timer = 0;
        ticks(10);
        exp_q.push_back(ex(2, 0, 1, 0, 0)); pulse(1, 0, 0, 0, 0); check("bg_count_start_ignored");

        // Adjust forces IDLE; clear beats start
        modo_ajuste_timer = 1;
        exp_q.push_back(ex(2, 10, 0, 0, 0)); @(posedge clk); #1; check("adjust_forces_idle");
        modo_ajuste_timer = 0; modo_timer = 1;
        exp_q.push_back(ex(2, 10, 1, 0, 0)); pulse(1, 0, 0, 0, 0); check("restart");
        exp_q.push_back(ex(2, 9, 1, 0, 0)); ticks(1); check("count_02_09");
        exp_q.push_back(ex(2, 10, 0, 0, 0)); pulse(1, 1, 0, 0, 0); check("clear_beats_start");

        // Zero preset: start ignored
        do_reset();
        modo_timer = 1;
        exp_q.push_back(ex(0, 0, 0, 0, 0)); pulse(1, 0, 0, 0, 1); check("zero_preset_start");

        // Async reset mid-EXPIRED
        do_reset();
        set_preset(0, 1);
        pulse(1, 0, 0, 0, 0);
        exp_q.push_back(ex(0, 0, 0, 1, 0)); ticks(1); check("expired_00_01");
        reset = 1; #1;
        exp_q.push_back(ex(0, 0, 0, 0, 0)); check("async_reset_expired");
        #2 reset = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
